clk_divider_prog: RTL
=====================

# clk_divider_prog

Runtime-programmable integer clock divider: divides `clk` by any N from 2 to 2^CNT_W-1 and produces a near-50% duty `clk_out` plus a one-cycle `tick` strobe per output period. The divide ratio is changed through a load/ack handshake. A new ratio only takes effect at an output-period boundary, so `clk_out` never produces a runt pulse. It replaces fixed divide-by-8 dividers in the clock-generation area and feeds downstream enables and slow strobes.

## Interface
- `CNT_W`, default 8: width of the counter and of the divide ratio.
- `RESET_DIV`, default 4: divide ratio after reset. Must be in the range 2..2^CNT_W-1.

Ports (clock and reset first):
- `clk`  in  1  system clock. All logic is clocked on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. Asserts immediately; deassertion is synchronous to `clk` externally.
- `en`  in  1  count enable. When 0, the divider freezes.
- `div_in`  in  CNT_W  requested divide ratio N.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_ack`  out  1  one-cycle pulse on the edge where a new ratio becomes active.
- `div_err`  out  1  one-cycle pulse when a load is rejected because `div_in` < 2.
- `div_active`  out  CNT_W  ratio currently in effect.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle strobe marking the first cycle of each output period.
- `count`  out  CNT_W  current phase counter, 0..div_active-1.

## Operation
- Reset values:
  - `count` = 0, `clk_out` = 0, `tick` = 0
  - `div_ack` = 0, `div_err` = 0
  - `div_active` = RESET_DIV
  - pending register empty
- Definitions: N = `div_active`, H = ceil(N/2).
- On each edge with `en`=1:
  - count_next = (count == N-1) ? 0 : count+1
  - `clk_out` <= (count_next < H)
  - `tick` <= (count_next == 0)
  - Result: `clk_out` is high for H cycles and low for floor(N/2) cycles. N even gives exact 50% duty; N odd is high one cycle longer than low.
- `en`=0: `count` and `clk_out` hold their values; `tick` is 0; pending ratio changes still apply (see below).
- Startup: the first enabled edge after reset moves `count` from 0 to 1. The reset-time period is therefore shortened by one cycle, and `clk_out` is 0 during the reset cycle. This is required and must not be "fixed" in the RTL.
- Load handling:
  - `div_load`=1 with `div_in` >= 2: `div_in` is captured into the pending register and marked valid. A later load overwrites an earlier unapplied one (last wins).
  - `div_load`=1 with `div_in` < 2: `div_err` pulses on the next edge. Pending register and `div_active` are unchanged.
- Apply: a valid pending ratio P is applied on the wrap edge (en=1 and count == N-1), or on any edge where en=0. On that edge:
  - `div_active` <= P and `count` <= 0
  - `clk_out` <= 1 and `tick` <= 1 when en=1
  - `div_ack` pulses and the pending register clears
- Simultaneous load and apply on the same edge: the previously pending value is applied, and the new `div_in` becomes the next pending value.
- Reset mid-period or with a load pending: everything returns to reset values; the pending load is discarded and no `div_ack` is issued.

## Timing
- Outputs `clk_out`, `tick`, `div_ack`, `div_err` and `count` are all registered; there are no combinational input-to-output paths.
- `div_err` follows the rejected `div_load` by 1 cycle.
- `div_ack` latency after `div_load`:
  - with en=1: between 1 and N cycles, depending on the current phase;
  - with en=0: 1 cycle.
- The first period at the new ratio begins on the `div_ack` edge, and `tick` is coincident with `div_ack` when en=1.
- The maximum N is 2^CNT_W-1. `count` never exceeds N-1, so no overflow or wrap beyond N-1 occurs.

## Test plan
- Reset, en=1, CNT_W=8, RESET_DIV=4, 20 cycles -> `count` sequence 1,2,3,0,1,…; `clk_out` pattern 1,0,0,1,1,0,0,1…; `tick` high on each count==0; `div_active`=4.
- Load 7 at count=1 -> no change until the count==3 edge; then `div_ack` and `tick` pulse, `div_active`=7, `clk_out` runs 4 high / 3 low with period 7.
- Load 5 then load 9 before the wrap -> only 9 is applied, with a single `div_ack`; load 1 -> `div_err` pulse next cycle, `div_active` unchanged.
- en=0 for 10 cycles mid-period -> `count` and `clk_out` frozen, `tick`=0; load 6 during the freeze -> `div_ack` after 1 cycle, and the period-6 pattern starts when en returns to 1.
- Assert `rst` asynchronously mid-period with a load pending -> outputs go to reset values immediately without waiting for a clock edge; `div_active`=4; no `div_ack` after release.
- Load N=255 and N=2 -> period 255 (128 high / 127 low) with no overflow; period 2 toggles every cycle.

Source files
------------

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable integer clock divider.
// Ratio changes land only on a period boundary (or while frozen), so clk_out never glitches.
module clk_divider_prog #(
    parameter int CNT_W     = 8,
    parameter int RESET_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic [CNT_W-1:0] div_active,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
    logic [CNT_W-1:0] pend_div;
    logic             pend_vld;
    logic             wrap;
    logic             apply;
    logic             load_ok;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W:0]   half;
    assign wrap      = count == div_active - ONE;
    assign apply     = pend_vld && (!en || wrap);
    assign load_ok   = div_load && div_in >= TWO;
    assign count_nxt = wrap ? '0 : count + ONE;
    // one bit wider so ceil(N/2) cannot overflow at N = 2^CNT_W-1
    assign half      = ({1'b0, div_active} + 1'b1) >> 1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            div_ack    <= 1'b0;
            div_err    <= 1'b0;
            div_active <= CNT_W'(RESET_DIV);
            pend_div   <= '0;
            pend_vld   <= 1'b0;
        end else begin
            div_ack <= apply;
            div_err <= div_load && !load_ok;
            if (load_ok) begin
                pend_vld <= 1'b1;
                pend_div <= div_in;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
            if (apply)
                div_active <= pend_div;
            // with en=1 an apply coincides with the wrap, so count_nxt is already 0
            if (en) begin
                count   <= count_nxt;
                clk_out <= {1'b0, count_nxt} < half;
                tick    <= count_nxt == '0;
            end else begin
                tick <= 1'b0;
                if (apply)
                    count <= '0;
            end
        end
    end
endmodule
